msf_low_time_scanner: RTL and testbench

- Sequences a read-only scan of the MSF second BRAM once per second and finds the address holding the minimum stored amplitude. That minimum marks the carrier-off gap at the start of each second.
- After the same minimum address is seen in CONFIRM_SCANS consecutive scans, converts it to a carrier-count and drives low_time into timing_control.
- Sits between the second-BRAM read port and timing_control.

---
 rtl/msf_low_time_scanner_if.sv | 31 +++
 rtl/msf_low_time_scanner.sv | 151 +++++++++++++++
 tb/tb_msf_low_time_scanner.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/msf_low_time_scanner_if.sv
// Bundles the scan request, second-BRAM read port and result signals of the low-time scanner.
// The scanner uses the slave modport; whoever drives requests and models the BRAM uses master.
interface msf_low_time_scanner_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  scan_start;
    logic [ADDR_WIDTH-1:0] num_entries;
    logic                  bram_en;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_rdata;
    logic                  scan_busy;
    logic                  scan_done;
    logic [DATA_WIDTH-1:0] min_value;
    logic [ADDR_WIDTH-1:0] min_index;
    logic [16:0]           low_time;
    logic                  low_time_valid;
    logic                  scan_overrun;

    modport master (
        output scan_start, num_entries, bram_rdata,
        input  bram_en, bram_addr, scan_busy, scan_done, min_value, min_index,
               low_time, low_time_valid, scan_overrun
    );

    modport slave (
        input  scan_start, num_entries, bram_rdata,
        output bram_en, bram_addr, scan_busy, scan_done, min_value, min_index,
               low_time, low_time_valid, scan_overrun
    );
endinterface

// File: rtl/msf_low_time_scanner.sv
// Scans the MSF second BRAM once per second for its minimum amplitude (the carrier-off gap)
// and, once the same address has won CONFIRM_SCANS scans in a row, publishes it as low_time.
module msf_low_time_scanner #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int READ_LATENCY   = 2,
    parameter int LOW_TIME_SHIFT = 3,
    parameter int CONFIRM_SCANS  = 3
) (
    input  logic                     clk,
    input  logic                     resetn,
    msf_low_time_scanner_if.slave    scan_if
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMMIT} state_t;

    localparam logic [16:0]           LOW_TIME_MAX = 17'h1FFFF;
    localparam logic [3:0]            CNT_MAX      = 4'(CONFIRM_SCANS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE     = ADDR_WIDTH'(1);

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   n_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    en_q;
    logic [READ_LATENCY-1:0] vld_q;
    logic [READ_LATENCY-1:0] vld_d;
    logic [ADDR_WIDTH-1:0]   tag_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   run_min_q;
    logic [ADDR_WIDTH-1:0]   run_idx_q;
    logic [DATA_WIDTH-1:0]   min_value_q;
    logic [ADDR_WIDTH-1:0]   min_index_q;
    logic [ADDR_WIDTH-1:0]   cand_q;
    logic [ADDR_WIDTH-1:0]   cand_d;
    logic [3:0]              cnt_q;
    logic [3:0]              cnt_d;
    logic [16:0]             low_time_q;
    logic [16:0]             low_time_d;
    logic [31:0]             shifted;
    logic                    valid_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    overrun_q;

    // Valid bits march alongside the read data so each returned word carries its address.
    assign vld_d[0] = en_q;
    for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_vld
        assign vld_d[gi] = vld_q[gi-1];
    end

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (run_idx_q == cand_q) begin
            if (cnt_q < CNT_MAX) cnt_d = cnt_q + 4'd1;
        end else begin
            cand_d = run_idx_q;
            cnt_d  = 4'd1;
        end
    end

    assign shifted    = 32'(run_idx_q) << LOW_TIME_SHIFT;
    assign low_time_d = (shifted > 32'(LOW_TIME_MAX)) ? LOW_TIME_MAX : shifted[16:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            n_q         <= '0;
            addr_q      <= '0;
            en_q        <= 1'b0;
            vld_q       <= '0;
            for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
            run_min_q   <= '1;
            run_idx_q   <= '0;
            min_value_q <= '1;
            min_index_q <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            low_time_q  <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            vld_q    <= vld_d;
            tag_q[0] <= addr_q;
            for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];

            if (scan_if.scan_start && busy_q) overrun_q <= 1'b1;

            // Strict less-than: on a tie the earlier (lower) address keeps the win.
            if (vld_q[READ_LATENCY-1] && (scan_if.bram_rdata < run_min_q)) begin
                run_min_q <= scan_if.bram_rdata;
                run_idx_q <= tag_q[READ_LATENCY-1];
            end

            case (state_q)
                IDLE: begin
                    if (scan_if.scan_start) begin
                        if (scan_if.num_entries != '0) begin
                            n_q       <= scan_if.num_entries;
                            run_min_q <= '1;
                            run_idx_q <= '0;
                            busy_q    <= 1'b1;
                            en_q      <= 1'b1;
                            addr_q    <= '0;
                            state_q   <= ISSUE;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (addr_q == n_q - ADDR_ONE) begin
                        en_q    <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        addr_q <= addr_q + ADDR_ONE;
                    end
                end
                DRAIN: begin
                    // Leave once the last in-flight word is being compared this cycle.
                    if (vld_d == '0) state_q <= COMMIT;
                end
                COMMIT: begin
                    min_value_q <= run_min_q;
                    min_index_q <= run_idx_q;
                    cand_q      <= cand_d;
                    cnt_q       <= cnt_d;
                    if (cnt_d == CNT_MAX) begin
                        low_time_q <= low_time_d;
                        valid_q    <= 1'b1;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign scan_if.bram_en        = en_q;
    assign scan_if.bram_addr      = addr_q;
    assign scan_if.scan_busy      = busy_q;
    assign scan_if.scan_done      = done_q;
    assign scan_if.min_value      = min_value_q;
    assign scan_if.min_index      = min_index_q;
    assign scan_if.low_time       = low_time_q;
    assign scan_if.low_time_valid = valid_q;
    assign scan_if.scan_overrun   = overrun_q;
endmodule

// File: tb/tb_msf_low_time_scanner.sv
// Bench for the MSF low-time scanner: unit 0 uses the default shift/confirm settings,
// unit 1 uses LOW_TIME_SHIFT=8, CONFIRM_SCANS=1 to reach the low_time saturation limit.
module tb_msf_low_time_scanner;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int RL = 2;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic          start_s [2];
    logic [AW-1:0] n_s     [2];
    logic [DW-1:0] mem     [2][1024];

    logic          done_w  [2];
    logic          busy_w  [2];
    logic          valid_w [2];
    logic          ovr_w   [2];
    logic          en_w    [2];
    logic [16:0]   lt_w    [2];
    logic [AW-1:0] idx_w   [2];
    logic [DW-1:0] minv_w  [2];

    task automatic check(input int u, input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL u%0d %s actual=%0d required=%0d at %0t", u, name, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_unit
        localparam int SHIFT = (gi == 0) ? 3 : 8;
        localparam int CONF  = (gi == 0) ? 3 : 1;

        msf_low_time_scanner_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

        msf_low_time_scanner #(
            .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL),
            .LOW_TIME_SHIFT(SHIFT), .CONFIRM_SCANS(CONF)
        ) dut (
            .clk(clk),
            .resetn(resetn),
            .scan_if(bus.slave)
        );

        // Second-BRAM read port: RL register stages between address and data.
        logic [DW-1:0] rd_pipe [RL];
        always @(posedge clk) begin
            if (bus.bram_en) rd_pipe[0] <= mem[gi][bus.bram_addr];
            for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
        assign bus.bram_rdata  = rd_pipe[RL-1];
        assign bus.scan_start  = start_s[gi];
        assign bus.num_entries = n_s[gi];

        assign done_w[gi]  = bus.scan_done;
        assign busy_w[gi]  = bus.scan_busy;
        assign valid_w[gi] = bus.low_time_valid;
        assign ovr_w[gi]   = bus.scan_overrun;
        assign en_w[gi]    = bus.bram_en;
        assign lt_w[gi]    = bus.low_time;
        assign idx_w[gi]   = bus.min_index;
        assign minv_w[gi]  = bus.min_value;

        // Reference model: timeline from scan_start (addr k issued k cycles after acceptance,
        // result N+RL+1 cycles after acceptance), minimum found by a plain loop over memory.
        logic          e_busy, e_done, e_en, e_valid, e_ovr;
        logic [AW-1:0] e_addr, e_idx, cand, s_idx;
        logic [DW-1:0] e_min, s_min;
        logic [16:0]   e_lt;
        int            cnt, t, e_n;
        longint        lt_full;

        initial forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                e_busy = 0; e_done = 0; e_en = 0; e_valid = 0; e_ovr = 0;
                e_addr = '0; e_idx = '0; cand = '0; s_idx = '0;
                e_min = '1; s_min = '1; e_lt = '0; cnt = 0; t = 0; e_n = 0;
            end else begin
                e_done = 0;
                if (start_s[gi] && e_busy) e_ovr = 1;
                if (!e_busy) begin
                    if (start_s[gi]) begin
                        if (n_s[gi] == '0) begin
                            e_done = 1;
                        end else begin
                            e_busy = 1; e_en = 1; e_addr = '0; t = 0; e_n = int'(n_s[gi]);
                            s_min = '1; s_idx = '0;
                            for (int i = 0; i < e_n; i++)
                                if (mem[gi][i] < s_min) begin s_min = mem[gi][i]; s_idx = AW'(i); end
                        end
                    end
                end else begin
                    t++;
                    if (t < e_n) e_addr = AW'(t);
                    if (t == e_n) e_en = 0;
                    if (t == e_n + RL + 1) begin
                        if (s_idx == cand) begin
                            if (cnt < CONF) cnt++;
                        end else begin
                            cand = s_idx; cnt = 1;
                        end
                        if (cnt == CONF) begin
                            lt_full = longint'(s_idx) << SHIFT;
                            e_lt = (lt_full > 131071) ? 17'h1FFFF : 17'(lt_full);
                            e_valid = 1;
                        end
                        e_min = s_min; e_idx = s_idx; e_done = 1; e_busy = 0;
                    end
                end
            end
        end

        initial forever begin
            @(negedge clk);
            if (chk_en) begin
                check(gi, "scan_busy",      longint'(bus.scan_busy),      longint'(e_busy));
                check(gi, "scan_done",      longint'(bus.scan_done),      longint'(e_done));
                check(gi, "bram_en",        longint'(bus.bram_en),        longint'(e_en));
                check(gi, "bram_addr",      longint'(bus.bram_addr),      longint'(e_addr));
                check(gi, "min_value",      longint'(bus.min_value),      longint'(e_min));
                check(gi, "min_index",      longint'(bus.min_index),      longint'(e_idx));
                check(gi, "low_time",       longint'(bus.low_time),       longint'(e_lt));
                check(gi, "low_time_valid", longint'(bus.low_time_valid), longint'(e_valid));
                check(gi, "scan_overrun",   longint'(bus.scan_overrun),   longint'(e_ovr));
            end
        end
    end

    task automatic fill(input int u, input logic [DW-1:0] v);
        for (int i = 0; i < 1024; i++) mem[u][i] = v;
    endtask

    // Launch one scan; pulse_at>0 re-asserts scan_start in that cycle of the scan.
    task automatic do_scan(input int u, input int n, input int exp_lat, input int pulse_at,
                           input int spacing);
        int lat;
        @(posedge clk); #1;
        start_s[u] = 1'b1; n_s[u] = AW'(n);
        @(posedge clk); #1;
        start_s[u] = 1'b0; lat = 1;
        while (!done_w[u] && lat < n + RL + 60) begin
            @(posedge clk); #1;
            lat++;
            start_s[u] = (lat == pulse_at);
        end
        start_s[u] = 1'b0;
        check(u, "scan_latency", longint'(lat), longint'(exp_lat));
        $display("[TB] scan u%0d n=%0d latency=%0d min_index=%0d min_value=%0d low_time=%0d valid=%0d overrun=%0d",
                 u, n, lat, idx_w[u], minv_w[u], lt_w[u], valid_w[u], ovr_w[u]);
        if (spacing > lat) repeat (spacing - lat) @(posedge clk);
    endtask

    task automatic wait_cycles(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    initial begin
        start_s[0] = 1'b0; start_s[1] = 1'b0;
        n_s[0] = '0; n_s[1] = '0;
        fill(0, 32'd1000);
        fill(1, 32'd1000);
        mem[0][37]  = 32'd5;
        mem[1][600] = 32'd5;

        @(posedge clk); #1;
        chk_en = 1'b1;
        wait_cycles(3);
        check(0, "reset_min_value", longint'(minv_w[0]), 64'hFFFF_FFFF);
        check(0, "reset_low_time",  longint'(lt_w[0]),   0);
        check(0, "reset_busy",      longint'(busy_w[0]), 0);
        resetn = 1'b1;
        wait_cycles(20);
        check(0, "idle_bram_en", longint'(en_w[0]), 0);

        // Lock onto index 37 over three scans.
        do_scan(0, 605, 609, 0, 2000);
        check(0, "scan1_index", longint'(idx_w[0]), 37);
        check(0, "scan1_value", longint'(minv_w[0]), 5);
        check(0, "scan1_valid", longint'(valid_w[0]), 0);
        do_scan(0, 605, 609, 0, 2000);
        check(0, "scan2_valid", longint'(valid_w[0]), 0);
        do_scan(0, 605, 609, 0, 2000);
        check(0, "scan3_valid", longint'(valid_w[0]), 1);
        check(0, "scan3_low_time", longint'(lt_w[0]), 296);

        // Tie between 10 and 20: lower index wins, low_time unchanged.
        mem[0][37] = 32'd1000; mem[0][10] = 32'd5; mem[0][20] = 32'd5;
        do_scan(0, 605, 609, 0, 700);
        check(0, "tie_index", longint'(idx_w[0]), 10);
        check(0, "tie_low_time", longint'(lt_w[0]), 296);

        // Minimum moves to 100: takes three scans to confirm.
        mem[0][10] = 32'd1000; mem[0][20] = 32'd1000; mem[0][100] = 32'd5;
        do_scan(0, 605, 609, 0, 700);
        check(0, "move1_low_time", longint'(lt_w[0]), 296);
        do_scan(0, 605, 609, 0, 700);
        check(0, "move2_low_time", longint'(lt_w[0]), 296);
        do_scan(0, 605, 609, 0, 700);
        check(0, "move3_low_time", longint'(lt_w[0]), 800);

        // scan_start during ISSUE is ignored but flagged.
        do_scan(0, 605, 609, 100, 700);
        check(0, "overrun_flag", longint'(ovr_w[0]), 1);
        check(0, "overrun_index", longint'(idx_w[0]), 100);

        // Empty scan: done next cycle, nothing else changes.
        do_scan(0, 0, 1, 0, 20);
        check(0, "empty_low_time", longint'(lt_w[0]), 800);
        check(0, "empty_valid", longint'(valid_w[0]), 1);

        // Reset during DRAIN aborts the scan.
        @(posedge clk); #1;
        start_s[0] = 1'b1; n_s[0] = AW'(605);
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        wait_cycles(606);
        resetn = 1'b0;
        @(negedge clk);
        check(0, "abort_busy",     longint'(busy_w[0]),  0);
        check(0, "abort_low_time", longint'(lt_w[0]),    0);
        check(0, "abort_valid",    longint'(valid_w[0]), 0);
        check(0, "abort_overrun",  longint'(ovr_w[0]),   0);
        check(0, "abort_min_value", longint'(minv_w[0]), 64'hFFFF_FFFF);
        wait_cycles(3);
        resetn = 1'b1;
        wait_cycles(5);
        do_scan(0, 605, 609, 0, 700);
        check(0, "after_reset_index", longint'(idx_w[0]), 100);
        check(0, "after_reset_valid", longint'(valid_w[0]), 0);

        // Saturation: 600 << 8 = 153600 exceeds 17 bits.
        do_scan(1, 601, 605, 0, 20);
        check(1, "sat_index", longint'(idx_w[1]), 600);
        check(1, "sat_low_time", longint'(lt_w[1]), 131071);
        check(1, "sat_valid", longint'(valid_w[1]), 1);

        wait_cycles(5);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
